// File: rtl/obi_bridge_arbiter_if.sv
// Bus bundle between the OBI initiators, the round-robin arbiter and the OBI-to-Wishbone bridge.
// The arbiter connects through "slave"; initiators and the bridge (or a bench) connect through "master".
interface obi_bridge_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]          m_req_i;
  logic [NUM_REQ-1:0]          m_gnt_o;
  logic [NUM_REQ*ADDR_W-1:0]   m_addr_i;
  logic [NUM_REQ-1:0]          m_we_i;
  logic [NUM_REQ*DATA_W/8-1:0] m_be_i;
  logic [NUM_REQ*DATA_W-1:0]   m_wdata_i;
  logic [NUM_REQ-1:0]          m_rvalid_o;
  logic [NUM_REQ-1:0]          m_err_o;
  logic [DATA_W-1:0]           m_rdata_o;
  logic                        s_req_o;
  logic                        s_gnt_i;
  logic [ADDR_W-1:0]           s_addr_o;
  logic                        s_we_o;
  logic [DATA_W/8-1:0]         s_be_o;
  logic [DATA_W-1:0]           s_wdata_o;
  logic                        s_rvalid_i;
  logic [DATA_W-1:0]           s_rdata_i;

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
  );

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
  );
endinterface

// File: rtl/obi_bridge_arbiter.sv
// Round-robin arbiter sharing the bridge's single OBI target port, one transaction in flight,
// with a per-phase watchdog that turns a hung grant or response into an error response.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's request
// REQ   | s_req_o high, waiting for the bridge grant (passed through to the winner)
// RESP  | granted, waiting for the bridge response (passed through to the winner)
// ERR   | one-cycle error response after a grant-phase timeout
module obi_bridge_arbiter #(
  parameter int unsigned       NUM_REQ        = 2,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                 obi_clk_i,
  input  logic                 rst_ni,
  obi_bridge_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic                 timeout_o
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, ptr_q;
  logic [WDOG_W-1:0]  wdog_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               we_q;
  logic [BE_W-1:0]    be_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               any_req, found, wdog_hit;
  logic [IDX_W-1:0]   winner, cand;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_we;
  logic [BE_W-1:0]    w_be;
  logic [DATA_W-1:0]  w_wdata;

  logic [NUM_REQ-1:0] gnt, rvalid, err;
  logic [DATA_W-1:0]  rdata;
  logic               timeout;

  assign any_req = |bus.m_req_i;

  // Search starts just after the last winner so every requester is served within NUM_REQ turns.
  always_comb begin
    winner  = ptr_q;
    cand    = ptr_q;
    found   = 1'b0;
    w_addr  = '0;
    w_we    = 1'b0;
    w_be    = '0;
    w_wdata = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.m_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        w_addr  = bus.m_addr_i[i*ADDR_W +: ADDR_W];
        w_we    = bus.m_we_i[i];
        w_be    = bus.m_be_i[i*BE_W +: BE_W];
        w_wdata = bus.m_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // A progress event in the same cycle as the watchdog limit always takes priority.
  always_comb begin
    state_d  = state_q;
    gnt      = '0;
    rvalid   = '0;
    err      = '0;
    rdata    = '0;
    timeout  = 1'b0;
    wdog_hit = WDOG_EN && (wdog_q == WDOG_LAST);
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = REQ;
      end
      REQ: begin
        if (bus.s_gnt_i) begin
          gnt[idx_q] = 1'b1;
          state_d    = RESP;
        end else if (wdog_hit) begin
          gnt[idx_q] = 1'b1;
          timeout    = 1'b1;
          state_d    = ERR;
        end
      end
      RESP: begin
        rdata = bus.s_rdata_i;
        if (bus.s_rvalid_i) begin
          rvalid[idx_q] = 1'b1;
          state_d       = IDLE;
        end else if (wdog_hit) begin
          rvalid[idx_q] = 1'b1;
          err[idx_q]    = 1'b1;
          rdata         = ERR_DATA;
          timeout       = 1'b1;
          state_d       = IDLE;
        end
      end
      ERR: begin
        rvalid[idx_q] = 1'b1;
        err[idx_q]    = 1'b1;
        rdata         = ERR_DATA;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge obi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      wdog_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wdog_q <= '0;
      end else if (state_q == REQ || state_q == RESP) begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (state_q == IDLE && any_req) begin
        idx_q   <= winner;
        addr_q  <= w_addr;
        we_q    <= w_we;
        be_q    <= w_be;
        wdata_q <= w_wdata;
      end
      if ((state_q == RESP || state_q == ERR) && state_d == IDLE) begin
        ptr_q <= idx_q;
      end
    end
  end

  assign bus.m_gnt_o    = gnt;
  assign bus.m_rvalid_o = rvalid;
  assign bus.m_err_o    = err;
  assign bus.m_rdata_o  = rdata;
  assign bus.s_req_o    = (state_q == REQ);
  assign bus.s_addr_o   = addr_q;
  assign bus.s_we_o     = we_q;
  assign bus.s_be_o     = be_q;
  assign bus.s_wdata_o  = wdata_q;
  assign busy_o         = (state_q != IDLE);
  assign timeout_o      = timeout;
endmodule

// File: tb/tb_obi_bridge_arbiter.sv
// Bench for obi_bridge_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-phase model of the arbiter.
module tb_obi_bridge_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;
  localparam logic [DW-1:0] ERRD = 32'hDEAD_BEEF;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_RESP = 2;
  localparam int PH_ERR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, tmo;
  int   total = 0;
  int   bad = 0;

  obi_bridge_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  obi_bridge_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)
  ) dut (
    .obi_clk_i(clk),
    .rst_ni   (rst_n),
    .bus      (bus),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-phase model: phase, winner, last winner, cycles spent in the phase, latched request.
  int              m_ph, m_win, m_last, m_age;
  logic [AW-1:0]   m_addr;
  logic            m_we;
  logic [BW-1:0]   m_be;
  logic [DW-1:0]   m_wd;
  logic [N-1:0]    e_gnt, e_rv, e_err, last_gnt;
  logic [DW-1:0]   e_rd;
  logic            e_to;
  bit              found;

  always @(negedge clk) begin
    last_gnt = bus.m_gnt_o;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0; e_to = 1'b0;
    if (!rst_n) begin
      m_ph = PH_IDLE; m_win = 0; m_last = N - 1; m_age = 0;
      m_addr = '0; m_we = 1'b0; m_be = '0; m_wd = '0;
    end
    chk("model s_req", bus.s_req_o, rst_n && m_ph == PH_REQ);
    chk("model busy", busy, rst_n && m_ph != PH_IDLE);
    chk("model s_addr", bus.s_addr_o, m_addr);
    chk("model s_we", bus.s_we_o, m_we);
    chk("model s_be", bus.s_be_o, m_be);
    chk("model s_wdata", bus.s_wdata_o, m_wd);
    if (rst_n) begin
      case (m_ph)
        PH_IDLE: if (bus.m_req_i != 0) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            if (!found && bus.m_req_i[(m_last + k) % N]) begin
              found = 1;
              m_win = (m_last + k) % N;
            end
          end
          m_addr = bus.m_addr_i[m_win*AW +: AW];
          m_we   = bus.m_we_i[m_win];
          m_be   = bus.m_be_i[m_win*BW +: BW];
          m_wd   = bus.m_wdata_i[m_win*DW +: DW];
          m_ph = PH_REQ; m_age = 0;
        end
        PH_REQ: begin
          if (bus.s_gnt_i) begin
            e_gnt[m_win] = 1'b1; m_ph = PH_RESP; m_age = 0;
          end else if (m_age == TO - 1) begin
            e_gnt[m_win] = 1'b1; e_to = 1'b1; m_ph = PH_ERR; m_age = 0;
          end else m_age++;
        end
        PH_RESP: begin
          if (bus.s_rvalid_i) begin
            e_rv[m_win] = 1'b1; e_rd = bus.s_rdata_i;
            m_last = m_win; m_ph = PH_IDLE; m_age = 0;
          end else if (m_age == TO - 1) begin
            e_rv[m_win] = 1'b1; e_err[m_win] = 1'b1; e_rd = ERRD; e_to = 1'b1;
            m_last = m_win; m_ph = PH_IDLE; m_age = 0;
          end else m_age++;
        end
        default: begin
          e_rv[m_win] = 1'b1; e_err[m_win] = 1'b1; e_rd = ERRD;
          m_last = m_win; m_ph = PH_IDLE; m_age = 0;
        end
      endcase
    end
    chk("model gnt", bus.m_gnt_o, e_gnt);
    chk("model rvalid", bus.m_rvalid_o, e_rv);
    chk("model err", bus.m_err_o, e_err);
    chk("model timeout", tmo, e_to);
    if (e_rv != 0) chk("model rdata", bus.m_rdata_o, e_rd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_req_i = '0; bus.m_addr_i = '0; bus.m_we_i = '0; bus.m_be_i = '0; bus.m_wdata_i = '0;
    bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0; bus.s_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic new_payload(input int i);
    bus.m_addr_i[i*AW +: AW]  = $urandom;
    bus.m_we_i[i]             = 1'($urandom_range(0, 1));
    bus.m_be_i[i*BW +: BW]    = BW'($urandom_range(1, 15));
    bus.m_wdata_i[i*DW +: DW] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    int wins[$];
    int idles;
    logic [N-1:0] prev_gnt;
    int gp, rp;

    // 1: single write from initiator 0
    do_reset();
    bus.m_req_i = 2'b01; bus.m_addr_i[31:0] = 32'h8000_0010; bus.m_we_i = 2'b01;
    bus.m_be_i[3:0] = 4'hF; bus.m_wdata_i[31:0] = 32'h1234_5678;
    #2 chk("t1 idle s_req", bus.s_req_o, 0);
    step(); #2;
    chk("t1 s_req", bus.s_req_o, 1);
    chk("t1 s_addr", bus.s_addr_o, 32'h8000_0010);
    chk("t1 s_we", bus.s_we_o, 1);
    chk("t1 s_be", bus.s_be_o, 4'hF);
    chk("t1 s_wdata", bus.s_wdata_o, 32'h1234_5678);
    chk("t1 no early gnt", bus.m_gnt_o, 2'b00);
    step(); #2 chk("t1 no gnt c2", bus.m_gnt_o, 2'b00);
    step(); bus.s_gnt_i = 1'b1;
    #2 chk("t1 gnt", bus.m_gnt_o, 2'b01);
    step(); bus.s_gnt_i = 1'b0; bus.m_req_i = 2'b00;
    #2 chk("t1 gnt one cycle", bus.m_gnt_o, 2'b00);
    chk("t1 resp busy", busy, 1);
    step(); step(); bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'h0BAD_0001;
    #2 chk("t1 rvalid", bus.m_rvalid_o, 2'b01);
    chk("t1 err", bus.m_err_o, 2'b00);
    step(); bus.s_rvalid_i = 1'b0;
    #2 chk("t1 busy drops", busy, 0);
    chk("t1 rvalid one cycle", bus.m_rvalid_o, 2'b00);

    // 2: contention, both requesting continuously, bridge always ready
    do_reset();
    bus.m_req_i = 2'b11; bus.s_gnt_i = 1'b1; bus.s_rvalid_i = 1'b1;
    idles = 0; prev_gnt = '0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (!busy) idles++;
      if (bus.m_gnt_o != 0) begin
        wins.push_back(bus.m_gnt_o[1] ? 1 : 0);
        prev_gnt = bus.m_gnt_o;
      end
      chk("t2 gnt onehot", $onehot0(bus.m_gnt_o), 1);
      if (bus.m_rvalid_o != 0) chk("t2 rvalid routed", bus.m_rvalid_o, prev_gnt);
      step();
    end
    chk("t2 grant count", wins.size(), 4);
    if (wins.size() == 4) begin
      chk("t2 win0", wins[0], 0); chk("t2 win1", wins[1], 1);
      chk("t2 win2", wins[2], 0); chk("t2 win3", wins[3], 1);
    end
    chk("t2 idle cycles", idles, 4);

    // 3: read routing to initiator 1, then ptr hands next turn to initiator 0
    do_reset();
    bus.m_addr_i = {32'h0000_0400, 32'h0000_0100};
    bus.m_req_i = 2'b10; bus.s_gnt_i = 1'b1;
    step(); #2;
    chk("t3 gnt", bus.m_gnt_o, 2'b10);
    chk("t3 s_addr", bus.s_addr_o, 32'h0000_0400);
    step(); bus.m_req_i = 2'b00; bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'hCAFE_F00D;
    #2 chk("t3 rvalid", bus.m_rvalid_o, 2'b10);
    chk("t3 rdata", bus.m_rdata_o, 32'hCAFE_F00D);
    chk("t3 err", bus.m_err_o, 2'b00);
    step(); bus.s_rvalid_i = 1'b0; bus.m_req_i = 2'b11;
    step(); #2;
    chk("t3 next winner", bus.m_gnt_o, 2'b01);
    chk("t3 next s_addr", bus.s_addr_o, 32'h0000_0100);
    step(); bus.m_req_i = 2'b00; bus.s_rvalid_i = 1'b1;
    step(); bus.s_rvalid_i = 1'b0;

    // 4: grant timeout
    do_reset();
    bus.m_req_i = 2'b01;
    step();
    for (int c = 1; c <= 8; c++) begin
      #2;
      if (c < 8) begin
        chk("t4 no gnt", bus.m_gnt_o, 2'b00);
        chk("t4 no timeout", tmo, 0);
        step();
      end else begin
        chk("t4 forced gnt", bus.m_gnt_o, 2'b01);
        chk("t4 timeout", tmo, 1);
      end
    end
    step(); bus.m_req_i = 2'b00;
    #2 chk("t4 err rvalid", bus.m_rvalid_o, 2'b01);
    chk("t4 err bit", bus.m_err_o, 2'b01);
    chk("t4 err data", bus.m_rdata_o, 32'hDEAD_BEEF);
    chk("t4 s_req dropped", bus.s_req_o, 0);
    chk("t4 timeout pulse", tmo, 0);
    step(); #2 chk("t4 idle", busy, 0);

    // 5: response timeout, then a stale rvalid in IDLE
    do_reset();
    bus.m_req_i = 2'b01; bus.s_gnt_i = 1'b1;
    step(); #2 chk("t5 gnt", bus.m_gnt_o, 2'b01);
    step(); bus.m_req_i = 2'b00; bus.s_gnt_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #2;
      if (c < 8) begin
        chk("t5 no rvalid", bus.m_rvalid_o, 2'b00);
        chk("t5 no timeout", tmo, 0);
        step();
      end else begin
        chk("t5 err rvalid", bus.m_rvalid_o, 2'b01);
        chk("t5 err bit", bus.m_err_o, 2'b01);
        chk("t5 err data", bus.m_rdata_o, 32'hDEAD_BEEF);
        chk("t5 timeout", tmo, 1);
      end
    end
    step(); step(); step(); bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'h5555_AAAA;
    #2 chk("t5 stale dropped", bus.m_rvalid_o, 2'b00);
    chk("t5 stale idle", busy, 0);
    step(); bus.s_rvalid_i = 1'b0;
    #2 chk("t5 still idle", busy, 0);

    // 6: reset during RESP
    do_reset();
    bus.m_addr_i[31:0] = 32'h0000_0A00; bus.m_wdata_i[31:0] = 32'h7777_0000;
    bus.m_req_i = 2'b01; bus.s_gnt_i = 1'b1;
    step(); bus.m_req_i = 2'b00; bus.s_gnt_i = 1'b0;
    step(); bus.s_rdata_i = 32'h1111_2222;
    rst_n = 1'b0;
    #1;
    chk("t6 busy", busy, 0);
    chk("t6 s_req", bus.s_req_o, 0);
    chk("t6 s_addr", bus.s_addr_o, 0);
    chk("t6 s_wdata", bus.s_wdata_o, 0);
    chk("t6 rvalid", bus.m_rvalid_o, 0);
    chk("t6 gnt", bus.m_gnt_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.m_req_i = 2'b11; bus.s_gnt_i = 1'b1;
    step(); #2 chk("t6 first winner", bus.m_gnt_o, 2'b01);
    step(); bus.m_req_i = 2'b00; bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b1;
    step(); bus.s_rvalid_i = 1'b0;

    // random traffic with alternating fast and slow bridge behaviour
    do_reset();
    gp = 6; rp = 6;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 256 == 0) begin
        gp = $urandom_range(0, 1) ? 6 : 1;
        rp = $urandom_range(0, 1) ? 6 : 1;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.m_req_i[i]) begin
          if (last_gnt[i]) begin
            if ($urandom_range(0, 1) == 1) new_payload(i);
            else bus.m_req_i[i] = 1'b0;
          end else if ($urandom_range(0, 63) == 0) begin
            bus.m_req_i[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.m_req_i[i] = 1'b1;
          new_payload(i);
        end
      end
      bus.s_gnt_i    = ($urandom_range(0, 7) < gp);
      bus.s_rvalid_i = ($urandom_range(0, 7) < rp);
      bus.s_rdata_i  = $urandom;
      step();
    end
    clear_inputs();
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/obi_bridge_arbiter.md
Name: obi_bridge_arbiter

Overview:
Shares the single OBI target port of the OBI-to-Wishbone bridge between NUM_REQ OBI initiators, such as core data port, debug module and DMA. It uses round-robin arbitration and holds one transaction in flight at a time, matching the bridge's single-outstanding behaviour. It routes gnt, rvalid and rdata back to the winning initiator. A watchdog terminates hung transactions with an error response so that an unresponsive Wishbone slave cannot lock up the SoC.

Parameters:
NUM_REQ, 2, number of OBI initiators (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, obi_clk_i cycles allowed per phase before forced error; 0 disables the watchdog
ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
obi_clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  NUM_REQ  per-initiator request
m_gnt_o  out  NUM_REQ  per-initiator grant
m_addr_i  in  NUM_REQ*ADDR_W  packed addresses; initiator i is at [i*ADDR_W +: ADDR_W]
m_we_i  in  NUM_REQ  write enables
m_be_i  in  NUM_REQ*DATA_W/8  packed byte enables
m_wdata_i  in  NUM_REQ*DATA_W  packed write data
m_rvalid_o  out  NUM_REQ  per-initiator response valid
m_err_o  out  NUM_REQ  per-initiator error, qualified by m_rvalid_o
m_rdata_o  out  DATA_W  read data shared by all initiators, qualified by m_rvalid_o
s_req_o  out  1  request to bridge
s_gnt_i  in  1  grant from bridge
s_addr_o  out  ADDR_W  latched address
s_we_o  out  1  latched write enable
s_be_o  out  DATA_W/8  latched byte enables
s_wdata_o  out  DATA_W  latched write data
s_rvalid_i  in  1  bridge response valid
s_rdata_i  in  DATA_W  bridge read data
busy_o  out  1  high whenever state is not IDLE
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is obi_clk_i.
- Reset values:
  - State = IDLE; all outputs 0; s_addr_o, s_we_o, s_be_o and s_wdata_o = 0.
  - idx (winner register) = 0; ptr (last winner) = NUM_REQ-1, so initiator 0 wins first; wdog = 0.
- State machine (IDLE, REQ, RESP, ERR):
  - IDLE: if any m_req_i is set, pick the winner by round-robin. The search order is ptr+1, ptr+2, … mod NUM_REQ; the first set bit wins. Register idx = winner and latch that initiator's addr/we/be/wdata onto the s_* registers. Next state is REQ. The decision cycle is also the latch cycle, so s_req_o rises 1 cycle after m_req_i.
  - REQ: s_req_o=1 and the s_* outputs stay stable. m_gnt_o[idx] = s_gnt_i, combinational pass-through. When s_gnt_i=1, go to RESP and clear wdog.
  - RESP: s_req_o=0. m_rvalid_o[idx] = s_rvalid_i, m_rdata_o = s_rdata_i, m_err_o=0, all combinational. When s_rvalid_i=1, set ptr=idx and go to IDLE.
  - ERR: for one cycle, m_rvalid_o[idx]=1, m_err_o[idx]=1, m_rdata_o=ERR_DATA. Then set ptr=idx and go to IDLE.
- Watchdog:
  - wdog increments each cycle in REQ or RESP and clears on any state change.
  - When TIMEOUT_CYCLES≠0 and wdog==TIMEOUT_CYCLES-1 with no progress event that cycle:
    - In REQ: drive m_gnt_o[idx]=1 (forced grant), drop s_req_o next cycle, pulse timeout_o, go to ERR.
    - In RESP: drive m_rvalid_o[idx]=1, m_err_o[idx]=1, m_rdata_o=ERR_DATA, pulse timeout_o, set ptr=idx, go to IDLE.
  - Simultaneous progress event and timeout: the progress event wins and no error is raised.
- Only idx's bits of m_gnt_o, m_rvalid_o and m_err_o may ever be 1. All other bits are 0 at all times.
- s_rvalid_i outside RESP is a stale or late response: it is dropped and has no effect on any output. s_gnt_i outside REQ is ignored.
- A requester that deasserts m_req_i after being latched but before its grant is an OBI protocol violation. The transaction still completes on the bridge side; the response goes to idx regardless.
- Initiators that receive a grant may re-request immediately. New arbitration happens only in IDLE, so the minimum turnaround is 1 IDLE cycle between transactions.
- Latency with an immediate s_gnt_i and s_rvalid_i: m_req_i → m_gnt_o is 1 cycle; gnt → rvalid is 1 cycle minimum.
- Reset asserted mid-transaction returns everything to reset values immediately. The bridge is reset by the same rst_ni.

Test Plan:
1. Write from initiator 0 only: m_req_i=2'b01, addr=0x8000_0010, we=1, be=4'hF, wdata=0x1234_5678; bridge grants 2 cycles after s_req_o and rvalids 3 cycles later → s_* carry the latched values; m_gnt_o=2'b01 for 1 cycle; m_rvalid_o=2'b01 for 1 cycle; m_err_o=0; busy_o drops the cycle after rvalid.
2. Contention: both initiators request continuously for 4 transactions → winner order 0,1,0,1; the non-winning bit of m_gnt_o/m_rvalid_o is never 1; exactly 1 IDLE cycle between transactions.
3. Read data routing: initiator 1 reads; bridge returns s_rdata_i=0xCAFE_F00D → m_rvalid_o=2'b10 with m_rdata_o=0xCAFE_F00D; the next arbitration starts with initiator 0 (ptr=1).
4. Grant timeout: TIMEOUT_CYCLES=8, s_gnt_i held 0 → m_gnt_o[idx]=1 and timeout_o=1 on the 8th REQ cycle; the next cycle gives m_rvalid_o[idx]=1, m_err_o[idx]=1, m_rdata_o=0xDEAD_BEEF; then IDLE.
5. Response timeout plus stale response: gnt is given, rvalid withheld → error response on the 8th RESP cycle; a late s_rvalid_i pulse 3 cycles later in IDLE → no m_rvalid_o bit rises.
6. Reset mid-RESP: rst_ni pulsed low during RESP → all outputs 0 asynchronously; after release, requests from both initiators → initiator 0 wins first.
